// File: rtl/fetch_controller_if.sv
// Fetch front-end bus bundle: branch redirect, memory port 1 reads,
// and the write side of the asynchronous instruction FIFO.
interface fetch_if #(
   parameter int ADDR_SIZE = 11,
   parameter int DATA_SIZE = 32
);
   logic                 branch_valid;
   logic [ADDR_SIZE-1:0] branch_address;
   logic                 mem_r_en;
   logic [ADDR_SIZE-1:0] mem_r_adrs;
   logic                 mem_r_valid;
   logic [DATA_SIZE-1:0] mem_r_data;
   logic                 fifo_full;
   logic                 fifo_w_en;
   logic [DATA_SIZE-1:0] fifo_w_data;
   logic                 fifo_flush_n;

   modport master (
      input  branch_valid, branch_address,
      input  mem_r_valid, mem_r_data, fifo_full,
      output mem_r_en, mem_r_adrs,
      output fifo_w_en, fifo_w_data, fifo_flush_n
   );

   modport slave (
      output branch_valid, branch_address,
      output mem_r_valid, mem_r_data, fifo_full,
      input  mem_r_en, mem_r_adrs,
      input  fifo_w_en, fifo_w_data, fifo_flush_n
   );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch front end: credit-limited sequential reads, skid
// buffer with bypass into the instruction FIFO, branch flush/redirect.
module fetch_controller #(
   parameter int ADDR_SIZE    = 11,
   parameter int DATA_SIZE    = 32,
   parameter int SKID_DEPTH   = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic     clk,
   input  logic     resetn,
   fetch_if.master  bus
);
   localparam int CW = $clog2(SKID_DEPTH + 1);
   localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CW-1:0] DEPTH      = CW'(SKID_DEPTH);
   localparam logic [PW-1:0] PTR_LAST   = PW'(SKID_DEPTH - 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

   typedef enum logic {S_FLUSH, S_RUN} state_t;

   state_t               state_q, state_d;
   logic [FW-1:0]        flush_cnt_q, flush_cnt_d;
   logic [ADDR_SIZE-1:0] pc_q, pc_d;
   logic [CW-1:0]        inflight_q, inflight_d;
   logic [CW-1:0]        stale_q, stale_d;
   logic [CW-1:0]        skid_cnt_q, skid_cnt_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [DATA_SIZE-1:0] skid_q [SKID_DEPTH];

   logic          run, branch, skid_ne, good;
   logic          issue, w_en, pop, push;
   logic [CW:0]   credit;

   assign run     = (state_q == S_RUN);
   assign branch  = bus.branch_valid;
   assign skid_ne = (skid_cnt_q != '0);
   assign good    = bus.mem_r_valid & (stale_q == '0);
   assign credit  = {1'b0, inflight_q} + {1'b0, skid_cnt_q};
   assign issue   = run & ~branch & (credit < {1'b0, DEPTH});
   assign w_en    = run & ~branch & ~bus.fifo_full & (skid_ne | good);
   assign pop     = w_en & skid_ne;
   // a good word goes to the skid unless it bypasses straight to the FIFO
   assign push    = good & ~branch & ~(w_en & ~skid_ne);

   assign bus.mem_r_en     = issue;
   assign bus.mem_r_adrs   = pc_q;
   assign bus.fifo_w_en    = w_en;
   assign bus.fifo_w_data  = skid_ne ? skid_q[rd_ptr_q] : bus.mem_r_data;
   assign bus.fifo_flush_n = run;

   // Flush sequencing: hold FIFO in flush, restart on every branch
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      if (branch) begin
         state_d     = S_FLUSH;
         flush_cnt_d = '0;
      end else begin
         unique case (state_q)
            S_FLUSH: begin
               if (flush_cnt_q == FLUSH_LAST) state_d = S_RUN;
               else flush_cnt_d = flush_cnt_q + FW'(1);
            end
            S_RUN: ;
            default: state_d = S_FLUSH;
         endcase
      end
   end

   // Next pc, credit counters and skid pointers
   always_comb begin
      pc_d       = pc_q;
      inflight_d = inflight_q;
      stale_d    = stale_q;
      skid_cnt_d = skid_cnt_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      if (branch) begin
         pc_d       = bus.branch_address;
         inflight_d = inflight_q - CW'(bus.mem_r_valid);
         stale_d    = inflight_q - CW'(bus.mem_r_valid);
         skid_cnt_d = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (issue) pc_d = pc_q + ADDR_SIZE'(1);
         inflight_d = inflight_q + CW'(issue) - CW'(bus.mem_r_valid);
         if (bus.mem_r_valid && !good) stale_d = stale_q - CW'(1);
         skid_cnt_d = skid_cnt_q + CW'(push) - CW'(pop);
         if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= S_FLUSH;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pc_q       <= '0;
         inflight_q <= '0;
         stale_q    <= '0;
         skid_cnt_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         stale_q    <= stale_d;
         skid_cnt_q <= skid_cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Skid storage, data only
   always_ff @(posedge clk) begin
      if (push) skid_q[wr_ptr_q] <= bus.mem_r_data;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
      !(push && !pop && skid_cnt_q == DEPTH));

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller against a queue-based model
// of issued reads, memory returns and the in-order FIFO stream.
module tb_fetch_controller;
   localparam int AW = 11;
   localparam int DW = 32;
   localparam int SD = 4;
   localparam int FC = 2;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   fetch_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

   fetch_controller #(
      .ADDR_SIZE(AW), .DATA_SIZE(DW),
      .SKID_DEPTH(SD), .FLUSH_CYCLES(FC)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [AW-1:0] adr;
   } req_t;

   req_t pipe[$];
   req_t expq[$];
   int   cyc = 0;
   int   lat = 1;
   int   since = 0;
   logic [AW-1:0] pc_m = '0;
   logic [AW-1:0] br_tgt = '0;
   bit   first_pending = 1'b1;
   int   n_wr = 0;
   int   checks = 0;
   int   failures = 0;

   function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
      return (DW'(a) * 32'h0100_0193) ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic rst, input logic bv,
                       input logic [AW-1:0] tgt, input logic full);
      int credit;
      bit run, exp_ren, exp_wen, ret;
      @(negedge clk);
      resetn = rst;
      bus.branch_valid   = bv;
      bus.branch_address = tgt;
      bus.fifo_full      = full;
      ret = (pipe.size() > 0) && (pipe[0].due == cyc);
      bus.mem_r_valid = ret;
      bus.mem_r_data  = ret ? word(pipe[0].adr) : DW'($urandom);
      #1;
      run = (since >= FC);
      credit = pipe.size();
      foreach (expq[i]) if (expq[i].due < cyc) credit++;
      exp_ren = run && !bv && (credit < SD);
      exp_wen = run && !bv && !full && (expq.size() > 0)
                && (expq[0].due <= cyc);
      check("flush_n", bus.fifo_flush_n, run);
      check("r_en", bus.mem_r_en, exp_ren);
      if (exp_ren) check("r_adrs", bus.mem_r_adrs, pc_m);
      check("w_en", bus.fifo_w_en, exp_wen);
      if (exp_wen) check("w_data", bus.fifo_w_data, word(expq[0].adr));
      if (exp_wen && first_pending) begin
         check("first_word", bus.fifo_w_data, word(br_tgt));
         first_pending = 1'b0;
      end
      if (bus.fifo_w_en) n_wr++;
      if (!rst) begin
         pipe.delete();
         expq.delete();
         pc_m = '0;
         since = 0;
         br_tgt = '0;
         first_pending = 1'b1;
      end else begin
         if (ret) void'(pipe.pop_front());
         if (exp_wen) void'(expq.pop_front());
         if (exp_ren) begin
            pipe.push_back(req_t'{cyc + lat, pc_m});
            expq.push_back(req_t'{cyc + lat, pc_m});
            pc_m = pc_m + AW'(1);
         end
         if (bv) begin
            expq.delete();
            pc_m = tgt;
            since = 0;
            br_tgt = tgt;
            first_pending = 1'b1;
         end else if (since < 1000) begin
            since++;
         end
      end
      cyc++;
   endtask

   task automatic run_n(input int n, input logic full);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, full);
   endtask

   task automatic quiesce(input int new_lat);
      run_n(16, 1'b1);
      if (pipe.size() == 0) lat = new_lat;
   endtask

   initial begin
      int w0;
      bus.branch_valid   = 1'b0;
      bus.branch_address = '0;
      bus.mem_r_valid    = 1'b0;
      bus.mem_r_data     = '0;
      bus.fifo_full      = 1'b0;

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
      check("rst_ren", bus.mem_r_en, 1'b0);
      check("rst_adrs", bus.mem_r_adrs, '0);
      check("rst_wen", bus.fifo_w_en, 1'b0);
      check("rst_flush", bus.fifo_flush_n, 1'b0);

      run_n(20, 1'b0);

      run_n(10, 1'b1);
      check("stall_ren", bus.mem_r_en, 1'b0);
      w0 = n_wr;
      run_n(4, 1'b0);
      check("stall_drain", 64'(n_wr - w0), 64'd4);
      run_n(6, 1'b0);

      step(1'b1, 1'b1, 11'h040, 1'b0);
      run_n(8, 1'b0);

      quiesce(3);
      run_n(8, 1'b0);
      step(1'b1, 1'b1, 11'h100, 1'b0);
      run_n(10, 1'b0);

      step(1'b1, 1'b1, 11'h7FD, 1'b0);
      run_n(10, 1'b0);

      step(1'b1, 1'b1, 11'h010, 1'b0);
      step(1'b1, 1'b1, 11'h020, 1'b0);
      run_n(10, 1'b0);

      run_n(10, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      check("rst_stall_wen", bus.fifo_w_en, 1'b0);
      run_n(12, 1'b0);

      for (int b = 0; b < 4; b++) begin
         quiesce(int'($urandom_range(1, 5)));
         for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            step(r != 0, $urandom_range(0, 99) < 3, AW'($urandom),
                 $urandom_range(0, 99) < 25);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
